// File: rtl/max_stream_feeder_pkg.sv
// Shared types and constants for the maxAccelerator stream feeder.
package max_pkg;

  localparam int DATA_W = 32;
  localparam int FRAC_W = 16;

  // Q16.16 reference values (two's complement).
  localparam logic [DATA_W-1:0] Q_ZERO = 32'h0000_0000;
  localparam logic [DATA_W-1:0] Q_MIN  = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/max_stream_feeder_if.sv
// Feeder-to-accelerator link.
// Handshake: the accelerator has no backpressure; every cycle with
// acc_valid=1 carries exactly one word on acc_data that the accelerator
// consumes. acc_data holds its last value while acc_valid=0. acc_result is
// the accelerator's running max, read by the feeder after the flush period.
interface max_stream_feeder_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] acc_data;
  logic              acc_valid;
  logic [DATA_W-1:0] acc_result;

  modport master (output acc_data, output acc_valid, input acc_result);
  modport slave  (input acc_data, input acc_valid, output acc_result);
endinterface

// File: rtl/max_stream_feeder_buf.sv
// Vector buffer: DEPTH x DATA_W register file, one write port and one
// registered read port whose output holds when no read is requested.
module feeder_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  // Storage array is not reset; only written words are ever read back.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Next read value: new word on a read, otherwise hold.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_addr];
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/max_stream_feeder.sv
// Stream source for maxAccelerator: buffers a host-loaded vector, bursts it
// out on start, waits FLUSH_CYCLES and captures the accelerator's max.
module max_stream_feeder
  import max_pkg::*;
#(
  parameter int DATA_W       = max_pkg::DATA_W,
  parameter int DEPTH        = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int CW           = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic              clear,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CW-1:0]     count,
  output logic [DATA_W-1:0] result,
  output state_t            dbg_state,
  max_stream_feeder_if.master acc
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     rd_idx_q, rd_idx_d;
  logic [FW-1:0]     flush_q, flush_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] result_q, result_d;

  logic              buf_wr;
  logic              buf_rd;
  logic [AW-1:0]     buf_rd_addr;
  logic [DATA_W-1:0] buf_rd_data;

  feeder_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (buf_wr),
    .wr_addr (count_q[AW-1:0]),
    .wr_data (wr_data),
    .rd_en   (buf_rd),
    .rd_addr (buf_rd_addr),
    .rd_data (buf_rd_data)
  );

  // Command decode, burst sequencing and flush timing; clear beats wr_en beats start.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_idx_d    = rd_idx_q;
    flush_d     = flush_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    result_d    = result_q;
    buf_wr      = 1'b0;
    buf_rd      = 1'b0;
    buf_rd_addr = rd_idx_q[AW-1:0];
    case (state_q)
      IDLE, DONE: begin
        if (clear) begin
          state_d = IDLE;
          count_d = '0;
        end else if (wr_en) begin
          if (count_q < CW'(DEPTH)) begin
            buf_wr  = 1'b1;
            count_d = count_q + CW'(1);
          end else begin
            err_d = 1'b1;
          end
          if (start) err_d = 1'b1;
        end else if (start) begin
          if (count_q != '0) begin
            state_d     = STREAM;
            buf_rd      = 1'b1;
            buf_rd_addr = '0;
            rd_idx_d    = CW'(1);
            valid_d     = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (clear) begin
          state_d  = IDLE;
          count_d  = '0;
          rd_idx_d = '0;
        end else begin
          if (wr_en || start) err_d = 1'b1;
          if (rd_idx_q < count_q) begin
            buf_rd   = 1'b1;
            rd_idx_d = rd_idx_q + CW'(1);
            valid_d  = 1'b1;
          end else begin
            state_d  = FLUSH;
            rd_idx_d = '0;
            flush_d  = '0;
          end
        end
      end
      FLUSH: begin
        if (clear) begin
          state_d = IDLE;
          count_d = '0;
          flush_d = '0;
        end else begin
          if (wr_en || start) err_d = 1'b1;
          if (flush_q == FW'(FLUSH_CYCLES - 1)) begin
            result_d = acc.acc_result;
            state_d  = DONE;
            flush_d  = '0;
          end else begin
            flush_d = flush_q + FW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == STREAM) || (state_d == FLUSH);
    done_d = (state_d == DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rd_idx_q <= '0;
      flush_q  <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= Q_ZERO;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_idx_q <= rd_idx_d;
      flush_q  <= flush_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign count         = count_q;
  assign result        = result_q;
  assign dbg_state     = state_q;
  assign acc.acc_data  = buf_rd_data;
  assign acc.acc_valid = valid_q;

endmodule

// File: tb/tb_max_stream_feeder.sv
// Bench for max_stream_feeder with a behavioural maxAccelerator model.
module tb_max_stream_feeder;
  import max_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        start;
  logic        clear;
  logic        busy, done, err;
  logic [4:0]  count;
  logic [31:0] result;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];

  max_stream_feeder_if #(.DATA_W(32)) acc_if ();

  max_stream_feeder dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .start     (start),
    .clear     (clear),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .count     (count),
    .result    (result),
    .dbg_state (dbg_state),
    .acc       (acc_if.master)
  );

  // Clock
  always #5 clk = ~clk;

  // Behavioural maxAccelerator: running signed max, restarted by each new burst.
  logic [31:0] m_max;
  logic        m_prev_v;
  always @(posedge clk) begin
    if (reset) begin
      m_max    <= 32'h0;
      m_prev_v <= 1'b0;
    end else begin
      if (acc_if.acc_valid && (!m_prev_v || $signed(acc_if.acc_data) > $signed(m_max)))
        m_max <= acc_if.acc_data;
      m_prev_v <= acc_if.acc_valid;
    end
  end
  assign acc_if.acc_result = m_max;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmd(input bit w, input logic [31:0] d, input bit s, input bit c);
    wr_en = w; wr_data = d; start = s; clear = c;
    step();
    wr_en = 1'b0; start = 1'b0; clear = 1'b0;
  endtask

  task automatic write_words(input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
    cmd(1, w0, 0, 0); cmd(1, w1, 0, 0); cmd(1, w2, 0, 0); cmd(1, w3, 0, 0);
  endtask

  // Start a burst and check length, order, contiguity, done latency and result.
  // With inject set, wr_en and start are pushed mid-burst and must be rejected.
  task automatic run_burst(input string name, input int n, input logic [31:0] exp_res,
                           input bit inject);
    int vcount = 0;
    int first_v = -1;
    int last_v = -1;
    int done_at = -1;
    int errs_seen = 0;
    int errs_exp = 0;
    bit gap = 1'b0;
    for (int k = 0; k < n + 12 && done_at < 0; k++) begin
      wr_en   = inject && (k == 1);
      wr_data = 32'hDEAD_BEEF;
      start   = (k == 0) || (inject && k == 2);
      step();
      wr_en = 1'b0; start = 1'b0;
      if (inject && (k == 1 || k == 2)) errs_exp++;
      if (err) errs_seen++;
      if (k == 0) chk({name, " busy_on_start"}, 32'(busy), 32'd1);
      if (acc_if.acc_valid) begin
        if (first_v < 0) first_v = k;
        if (last_v >= 0 && k != last_v + 1) gap = 1'b1;
        last_v = k;
        vcount++;
        if (exp_q.size() == 0) begin
          chk({name, " extra_word"}, acc_if.acc_data, 32'hxxxx_xxxx);
        end else begin
          chk({name, " data"}, acc_if.acc_data, exp_q.pop_front());
        end
      end
      if (done && done_at < 0) done_at = k;
    end
    chk({name, " burst_len"}, 32'(vcount), 32'(n));
    chk({name, " first_word_cycle"}, 32'(first_v), 32'd0);
    chk({name, " gap"}, 32'(gap), 32'd0);
    chk({name, " done_latency"}, 32'(done_at), 32'(n + 2));
    chk({name, " result"}, result, exp_res);
    chk({name, " err_pulses"}, 32'(errs_seen), 32'(errs_exp));
    chk({name, " count_kept"}, 32'(count), 32'(n));
    chk({name, " busy_after"}, 32'(busy), 32'd0);
    exp_q.delete();
  endtask

  typedef struct {
    bit          wr_en;
    logic [31:0] wr_data;
    bit          start;
    bit          clear;
    bit          exp_err;
    int          exp_count;
    bit          exp_busy;
    bit          exp_done;
  } vec_t;

  vec_t vecs[$];

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = '0; start = 1'b0; clear = 1'b0;

    // Reset state
    step(); step();
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst count", 32'(count), 32'd0);
    chk("rst result", result, 32'h0);
    chk("rst acc_valid", 32'(acc_if.acc_valid), 32'd0);
    chk("rst acc_data", acc_if.acc_data, 32'h0);
    chk("rst state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;
    step();

    // Test 1: positive Q16.16 values
    write_words(32'h0000_8000, 32'h0003_8000, 32'h0002_8000, 32'h0001_8000);
    chk("t1 count", 32'(count), 32'd4);
    exp_q = '{32'h0000_8000, 32'h0003_8000, 32'h0002_8000, 32'h0001_8000};
    run_burst("t1", 4, 32'h0003_8000, 1'b0);
    chk("t1 done", 32'(done), 32'd1);
    chk("t1 state", 32'(dbg_state), 32'(DONE));

    // Test 2: negative values, then restart from DONE
    cmd(0, 0, 0, 1);
    chk("t2 clear done", 32'(done), 32'd0);
    chk("t2 clear count", 32'(count), 32'd0);
    write_words(32'hFFFE_0000, 32'hFFFD_0000, 32'hFFFC_0000, 32'hFFFF_0000);
    exp_q = '{32'hFFFE_0000, 32'hFFFD_0000, 32'hFFFC_0000, 32'hFFFF_0000};
    run_burst("t2a", 4, 32'hFFFF_0000, 1'b0);
    chk("t2 result_held", result, 32'hFFFF_0000);
    exp_q = '{32'hFFFE_0000, 32'hFFFD_0000, 32'hFFFC_0000, 32'hFFFF_0000};
    run_burst("t2b", 4, 32'hFFFF_0000, 1'b0);

    // Write in DONE: stays DONE, count grows, result held
    cmd(1, 32'h0000_0000, 0, 0);
    chk("done_wr done", 32'(done), 32'd1);
    chk("done_wr count", 32'(count), 32'd5);
    chk("done_wr result", result, 32'hFFFF_0000);

    // Test 6: wr_en and start during STREAM
    exp_q = '{32'hFFFE_0000, 32'hFFFD_0000, 32'hFFFC_0000, 32'hFFFF_0000, 32'h0000_0000};
    run_burst("t6", 5, 32'h0000_0000, 1'b1);

    // Tests 3/4 as a vector table
    vecs.push_back('{0, 32'h0, 0, 1, 0, 0, 0, 0});          // clear
    vecs.push_back('{0, 32'h0, 1, 0, 1, 0, 0, 0});          // start empty
    vecs.push_back('{1, 32'h1234_5678, 1, 0, 1, 1, 0, 0});  // wr+start
    vecs.push_back('{0, 32'h0, 0, 1, 0, 0, 0, 0});          // clear
    for (int i = 0; i < 16; i++)
      vecs.push_back('{1, 32'((i - 8) * 65536), 0, 0, 0, i + 1, 0, 0});
    vecs.push_back('{1, 32'h7FFF_FFFF, 0, 0, 1, 16, 0, 0}); // 17th write
    for (int i = 0; i < vecs.size(); i++) begin
      cmd(vecs[i].wr_en, vecs[i].wr_data, vecs[i].start, vecs[i].clear);
      chk($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].exp_done));
      chk($sformatf("vec%0d acc_valid", i), 32'(acc_if.acc_valid), 32'd0);
      if (i == 1) chk("t4 state", 32'(dbg_state), 32'(IDLE));
    end
    for (int i = 0; i < 16; i++) exp_q.push_back(32'((i - 8) * 65536));
    run_burst("t3", 16, 32'h0007_0000, 1'b0);

    // Test 5: reset after two burst words
    start = 1'b1; step(); start = 1'b0;
    step();
    chk("t5 valid_before", 32'(acc_if.acc_valid), 32'd1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("t5 acc_valid", 32'(acc_if.acc_valid), 32'd0);
    chk("t5 busy", 32'(busy), 32'd0);
    chk("t5 done", 32'(done), 32'd0);
    chk("t5 count", 32'(count), 32'd0);
    chk("t5 state", 32'(dbg_state), 32'(IDLE));
    step();
    chk("t5 acc_valid_later", 32'(acc_if.acc_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
